// File: rtl/alarm_trigger.sv
// alarm_trigger: alarm-time compare plus ring/snooze/stop FSM driving the buzzer.
// Define ALARM_BEEP_PATTERN_EN for a 1 s on / 1 s off beep instead of a continuous tone.
module alarm_trigger #(
   parameter int RING_SECONDS   = 60,
   parameter int SNOOZE_MINUTES = 9,
   parameter int MAX_SNOOZES    = 3,
   parameter int TIMER_W        = 10
) (
   input  logic               C,
   input  logic               CLR,
   input  logic               TICK,
   input  logic [5:0]         CUR_MINUTES,
   input  logic [4:0]         CUR_HOURS,
   input  logic [5:0]         ALARM_MINUTES,
   input  logic [4:0]         ALARM_HOURS,
   input  logic               ALARM_EN,
   input  logic               SNOOZE,
   input  logic               STOP,
   output logic               BUZZER,
   output logic [1:0]         STATE,
   output logic [2:0]         SNOOZE_COUNT,
   output logic [TIMER_W-1:0] TIMER
);
   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      RINGING  = 2'b01,
      SNOOZING = 2'b10,
      HOLDOFF  = 2'b11
   } state_t;

   localparam logic [TIMER_W-1:0] RING_LAST   = TIMER_W'(RING_SECONDS - 1);
   localparam logic [TIMER_W-1:0] SNOOZE_LOAD = TIMER_W'(SNOOZE_MINUTES * 60);
   localparam logic [TIMER_W-1:0] T_ONE       = TIMER_W'(1);
   localparam logic [2:0]         MAX_S       = 3'(MAX_SNOOZES);

   state_t               state_q, state_d;
   logic [TIMER_W-1:0]   timer_q, timer_d;
   logic [2:0]           cnt_q, cnt_d;
   logic                 buzz_q, buzz_d;
   logic                 match;

   assign match = (CUR_MINUTES == ALARM_MINUTES) && (CUR_HOURS == ALARM_HOURS);

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      cnt_d   = cnt_q;
      if (!ALARM_EN) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: if (match) begin
               state_d = RINGING;
               timer_d = '0;
               cnt_d   = '0;
            end
            RINGING: if (STOP) begin
               state_d = HOLDOFF;
            end else if (SNOOZE && cnt_q < MAX_S) begin
               state_d = SNOOZING;
               timer_d = SNOOZE_LOAD;
               cnt_d   = cnt_q + 3'd1;
            end else if (TICK) begin
               if (timer_q >= RING_LAST) state_d = HOLDOFF;
               else timer_d = timer_q + T_ONE;
            end
            SNOOZING: if (STOP) begin
               state_d = HOLDOFF;
            end else if (TICK) begin
               if (timer_q == T_ONE) begin
                  state_d = RINGING;
                  timer_d = '0;
               end else if (timer_q != '0) begin
                  timer_d = timer_q - T_ONE;
               end
            end
            default: if (!match) state_d = IDLE;
         endcase
      end
      if (state_d == IDLE) cnt_d = '0;
`ifdef ALARM_BEEP_PATTERN_EN
      // buzz_q doubles as the beep phase: set on entry, toggled per TICK while ringing
      buzz_d = (state_d != RINGING) ? 1'b0 :
               (state_q != RINGING) ? 1'b1 :
               TICK ? ~buzz_q : buzz_q;
`else
      buzz_d = (state_d == RINGING);
`endif
   end

   always_ff @(posedge C or posedge CLR) begin
      if (CLR) begin
         state_q <= IDLE;
         timer_q <= '0;
         cnt_q   <= '0;
         buzz_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         cnt_q   <= cnt_d;
         buzz_q  <= buzz_d;
      end
   end

   assign BUZZER       = buzz_q;
   assign STATE        = state_q;
   assign SNOOZE_COUNT = cnt_q;
   assign TIMER        = timer_q;
endmodule
